coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
Front-end stage for the vending FSM. Converts the two raw, asynchronous, bouncy coin-sensor lines (5-unit and 10-unit) into the clean `coin[1:0]` code the vending FSM consumes: one-cycle 2'b01 / 2'b10 pulses, 2'b00 otherwise. Synchronises, debounces and rejects jams (both sensors active), so each physical coin yields exactly one pulse.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable clk cycles required to qualify a coin and to qualify release; legal range 1..2**CNT_W-1
CNT_W, 4, width of the internal debounce counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
sense5  input  1  raw 5-unit sensor, asynchronous, active-high
sense10  input  1  raw 10-unit sensor, asynchronous, active-high
coin  output  2  to vending FSM: 2'b01 = +5, 2'b10 = +10, 2'b00 = idle; 2'b11 never driven
jam  output  1  high while in JAM state
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n low.
- Reset values: coin=2'b00, jam=0, busy=1 (reset state is RELEASE), sync flops=0, cnt=0.
- Synchroniser: two flops per sensor. s5, s10 denote the synchronised values. No logic uses the raw inputs.
- Outputs are registered. coin is never high for more than one consecutive cycle.
- State IDLE:
  - exactly one of s5/s10 high -> QUAL; latch sel (5 or 10); cnt=1.
  - both high -> JAM; cnt=0.
  - neither high -> stay.
- State QUAL:
  - other sensor goes high -> JAM; cnt=0.
  - sel sensor drops low -> IDLE; no pulse; glitch discarded.
  - sel still high and cnt<DEBOUNCE_CYCLES -> cnt+1.
  - sel still high and cnt==DEBOUNCE_CYCLES -> RELEASE; coin<=code for exactly that one following cycle; cnt=0.
- State RELEASE:
  - coin=00.
  - both sensors low -> cnt+1; any sensor high -> cnt=0.
  - cnt reaches DEBOUNCE_CYCLES with both low -> IDLE.
  - A second coin is accepted only after release qualifies.
- State JAM:
  - jam=1; coin=00; same release-qualification rule as RELEASE -> IDLE, jam=0.
  - No coin is ever credited for a jam event.
- Latency: edge k is the first to sample raw sense high, with the sensor held stable. coin is high in the cycle after edge k+DEBOUNCE_CYCLES+2 and low again after edge k+DEBOUNCE_CYCLES+3.
- Boundaries:
  - Sensor already high at reset release: not counted; it must drop for DEBOUNCE_CYCLES first (reset state is RELEASE).
  - Reset mid-QUAL: pulse is lost, no partial credit.
  - Reset during a coin pulse: coin clears immediately.
  - Counter never wraps; it saturates at DEBOUNCE_CYCLES.

Optional Feature:
COIN_TALLY_EN
- Defined: adds output ports tally5[7:0] and tally10[7:0], reset 0.
  - Incremented on the same edge that loads coin=01 / coin=10 respectively.
  - Saturating at 255; jam events are not tallied.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset low then high, sensors low for 4 cycles -> busy falls to 0 (IDLE), coin=00 throughout, jam=0.
- sense5 high 10 cycles from edge k (D=4) -> coin=01 exactly in the cycle after edge k+6, 00 otherwise; sense10 likewise -> coin=10 once.
- sense10 high 2 cycles then low (bounce) -> coin stays 00, state returns IDLE; a following clean 10-cycle pulse -> one coin=10.
- sense5 high, sense10 raised 2 cycles later, both held 6 cycles, then both low 4 cycles -> jam=1 until release qualifies, coin never non-zero, then busy=0.
- sense5 held high through reset deassertion, then low 4 cycles, then clean sense5 pulse -> exactly one coin=01 (the held one is not credited).
- With COIN_TALLY_EN: 300 clean sense10 coins -> tally10=255 (saturated), tally5=0; rst_n pulse -> both 0.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises the two raw sensor lines, debounces them and rejects jams,
// giving one registered coin pulse per physical coin. Optional per-denomination tallies via COIN_TALLY_EN.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sense5,
    input  logic       sense10,
    output logic [1:0] coin,
    output logic       jam,
    output logic       busy
`ifdef COIN_TALLY_EN
    ,
    output logic [7:0] tally5,
    output logic [7:0] tally10
`endif
);

    localparam logic [CNT_W-1:0] DC = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_JAM     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;     // 0: 5-unit coin being qualified, 1: 10-unit
    logic [1:0]       coin_q, coin_d;
    logic             jam_q, busy_q;
    logic             s5_meta_q, s5_q, s10_meta_q, s10_q;
    logic             held, other;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s5_meta_q  <= 1'b0;
            s5_q       <= 1'b0;
            s10_meta_q <= 1'b0;
            s10_q      <= 1'b0;
        end else begin
            s5_meta_q  <= sense5;
            s5_q       <= s5_meta_q;
            s10_meta_q <= sense10;
            s10_q      <= s10_meta_q;
        end
    end

    assign held  = sel_q ? s10_q : s5_q;
    assign other = sel_q ? s5_q  : s10_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        coin_d  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (s5_q && s10_q) begin
                    state_d = ST_JAM;
                    cnt_d   = '0;
                end else if (s5_q || s10_q) begin
                    state_d = ST_QUAL;
                    sel_d   = s10_q;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_QUAL: begin
                if (other) begin
                    state_d = ST_JAM;
                    cnt_d   = '0;
                end else if (!held) begin
                    // short glitch: discard without credit
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DC) begin
                    state_d = ST_RELEASE;
                    coin_d  = sel_q ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE, ST_JAM: begin
                // both sensors must read low for DEBOUNCE_CYCLES samples before rearming
                if (s5_q || s10_q) begin
                    cnt_d = '0;
                end else if (cnt_q >= DC - CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            coin_q  <= 2'b00;
            jam_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            coin_q  <= coin_d;
            jam_q   <= (state_d == ST_JAM);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign coin = coin_q;
    assign jam  = jam_q;
    assign busy = busy_q;

`ifdef COIN_TALLY_EN
    logic [7:0] tally5_q, tally10_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tally5_q  <= 8'd0;
            tally10_q <= 8'd0;
        end else begin
            if (coin_d == 2'b01 && tally5_q != 8'hFF)
                tally5_q <= tally5_q + 8'd1;
            if (coin_d == 2'b10 && tally10_q != 8'hFF)
                tally10_q <= tally10_q + 8'd1;
        end
    end

    assign tally5  = tally5_q;
    assign tally10 = tally10_q;
`endif

endmodule
